br_commit_unit: RTL and testbench

//  Per-ROB-entry branch/jump record keeper and commit-time update generator. Captures predictions at decode,

---
 rtl/br_commit_unit_pkg.sv | 37 +++
 rtl/br_commit_unit_if.sv | 66 ++++++
 rtl/br_commit_unit_record_table.sv | 75 +++++++
 rtl/br_commit_unit.sv | 202 ++++++++++++++++++++
 tb/tb_br_commit_unit.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/br_commit_unit_pkg.sv
// Shared types and sizes for the branch commit unit.
// Optional statistics counters are enabled by defining BR_COMMIT_STAT_EN.
package br_commit_unit_pkg;

    localparam int ADDR_W      = 32;
    localparam int ROB_DEPTH_D = 8;
    localparam int ROB_W       = $clog2(ROB_DEPTH_D);

    // Strobe order: br_commit_, br_taken_, br_miss_,
    // jump_commit_, jump_call_, jump_return_, jump_miss_
    localparam logic [6:0] STRB_IDLE = 7'h7F;

    typedef enum logic [1:0] {
        BRTYPE_BRANCH = 2'd0,
        BRTYPE_JUMP   = 2'd1,
        BRTYPE_CALL   = 2'd2,
        BRTYPE_RETURN = 2'd3
    } br_inst_type_t;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_DECODED  = 2'd1,
        ST_RESOLVED = 2'd2
    } br_status_t;

    typedef struct packed {
        br_inst_type_t     kind;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] pred_addr;
        logic              br_pred;
        logic [ADDR_W-1:0] tar_pc;
        logic              taken;
        logic              pred_miss;
        logic              jump_miss;
    } br_record_t;

endpackage

// File: rtl/br_commit_unit_if.sv
// Decode/exe/writeback/commit bus of the branch commit unit.
// Statistics ports exist only when BR_COMMIT_STAT_EN is defined.
interface br_commit_unit_if;
    import br_commit_unit_pkg::*;

    logic              flush_;
    logic              dec_e_;
    br_inst_type_t     dec_type;
    logic [ROB_W-1:0]  dec_rob_id;
    logic [ADDR_W-1:0] dec_pc;
    logic [ADDR_W-1:0] dec_pred_addr;
    logic              dec_br_pred;
    logic [ROB_W-1:0]  exe_rob_id;
    logic [ADDR_W-1:0] exe_pred_addr;
    logic              exe_br_pred;
    logic              wb_e_;
    logic [ROB_W-1:0]  wb_rob_id;
    logic [ADDR_W-1:0] wb_tar_pc;
    logic              wb_taken_;
    logic              wb_pred_miss_;
    logic              wb_jump_miss_;
    logic              commit_;
    logic [ROB_W-1:0]  com_rob_id;
    logic              br_commit_;
    logic              br_taken_;
    logic              br_miss_;
    logic              jump_commit_;
    logic              jump_call_;
    logic              jump_return_;
    logic              jump_miss_;
    logic [ADDR_W-1:0] com_addr;
    logic [ADDR_W-1:0] com_tar_addr;
`ifdef BR_COMMIT_STAT_EN
    logic [31:0]       stat_br_cnt;
    logic [31:0]       stat_miss_cnt;
`endif

    modport slave (
        input  flush_, dec_e_, dec_type, dec_rob_id, dec_pc,
        input  dec_pred_addr, dec_br_pred, exe_rob_id,
        input  wb_e_, wb_rob_id, wb_tar_pc, wb_taken_,
        input  wb_pred_miss_, wb_jump_miss_, commit_, com_rob_id,
        output exe_pred_addr, exe_br_pred,
        output br_commit_, br_taken_, br_miss_,
        output jump_commit_, jump_call_, jump_return_, jump_miss_,
        output com_addr, com_tar_addr
`ifdef BR_COMMIT_STAT_EN
        , output stat_br_cnt, stat_miss_cnt
`endif
    );

    modport master (
        output flush_, dec_e_, dec_type, dec_rob_id, dec_pc,
        output dec_pred_addr, dec_br_pred, exe_rob_id,
        output wb_e_, wb_rob_id, wb_tar_pc, wb_taken_,
        output wb_pred_miss_, wb_jump_miss_, commit_, com_rob_id,
        input  exe_pred_addr, exe_br_pred,
        input  br_commit_, br_taken_, br_miss_,
        input  jump_commit_, jump_call_, jump_return_, jump_miss_,
        input  com_addr, com_tar_addr
`ifdef BR_COMMIT_STAT_EN
        , input stat_br_cnt, stat_miss_cnt
`endif
    );

endinterface

// File: rtl/br_commit_unit_record_table.sv
// Per-ROB-slot branch record storage: decode and writeback write
// ports, combinational exe and commit read ports.
module br_record_table
    import br_commit_unit_pkg::*;
#(
    parameter int ADDR  = ADDR_W,
    parameter int DEPTH = ROB_DEPTH_D,
    parameter int ID_W  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset_,
    input  logic            dec_we,
    input  logic [ID_W-1:0] dec_id,
    input  br_inst_type_t   dec_kind,
    input  logic [ADDR-1:0] dec_pc,
    input  logic [ADDR-1:0] dec_pred_addr,
    input  logic            dec_br_pred,
    input  logic            wb_we,
    input  logic [ID_W-1:0] wb_id,
    input  logic [ADDR-1:0] wb_tar_pc,
    input  logic            wb_taken,
    input  logic            wb_pred_miss,
    input  logic            wb_jump_miss,
    input  logic [ID_W-1:0] exe_id,
    output logic [ADDR-1:0] exe_pred_addr,
    output logic            exe_br_pred,
    input  logic [ID_W-1:0] com_id,
    output br_inst_type_t   com_kind,
    output logic [ADDR-1:0] com_pc,
    output logic [ADDR-1:0] com_tar_pc,
    output logic            com_taken,
    output logic            com_pred_miss,
    output logic            com_jump_miss
);

    br_record_t mem [DEPTH];

    // Writes: the decode write is last so it wins on a shared slot.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wb_we) begin
                mem[wb_id].tar_pc    <= wb_tar_pc;
                mem[wb_id].taken     <= wb_taken;
                mem[wb_id].pred_miss <= wb_pred_miss;
                mem[wb_id].jump_miss <= wb_jump_miss;
            end
            if (dec_we) begin
                mem[dec_id] <= '{
                    kind:      dec_kind,
                    pc:        dec_pc,
                    pred_addr: dec_pred_addr,
                    br_pred:   dec_br_pred,
                    tar_pc:    '0,
                    taken:     1'b0,
                    pred_miss: 1'b0,
                    jump_miss: 1'b0
                };
            end
        end
    end

    assign exe_pred_addr = mem[exe_id].pred_addr;
    assign exe_br_pred   = mem[exe_id].br_pred;
    assign com_kind      = mem[com_id].kind;
    assign com_pc        = mem[com_id].pc;
    assign com_tar_pc    = mem[com_id].tar_pc;
    assign com_taken     = mem[com_id].taken;
    assign com_pred_miss = mem[com_id].pred_miss;
    assign com_jump_miss = mem[com_id].jump_miss;

endmodule

// File: rtl/br_commit_unit.sv
// Branch record keeper and commit-time BTB/predictor/RAS update pulses.
// Define BR_COMMIT_STAT_EN to add saturating commit/miss counters.
module br_commit_unit
    import br_commit_unit_pkg::*;
#(
    parameter int ADDR      = ADDR_W,
    parameter int ROB_DEPTH = ROB_DEPTH_D
) (
    input logic             clk,
    input logic             reset_,
    br_commit_unit_if.slave bus
);

    localparam int ROB = $clog2(ROB_DEPTH);

    logic            flush;
    logic            dec_v;
    logic            wb_v;
    logic            com_v;
    logic [ROB-1:0]  dec_id;
    logic [ROB-1:0]  wb_id;
    logic [ROB-1:0]  com_id;
    logic            wb_we;
    logic            wb_byp;
    logic            com_fire;
    br_status_t      status_q [ROB_DEPTH];
    br_status_t      status_d [ROB_DEPTH];
    logic [ADDR-1:0] t_exe_pred;
    logic            t_exe_brp;
    br_inst_type_t   t_kind;
    logic [ADDR-1:0] t_pc;
    logic [ADDR-1:0] t_tar;
    logic            t_taken;
    logic            t_pmiss;
    logic            t_jmiss;
    logic [ADDR-1:0] c_tar;
    logic            c_taken;
    logic            c_pmiss;
    logic            c_jmiss;
    logic [6:0]      strb_d;
    logic [6:0]      strb_q;
    logic [ADDR-1:0] com_addr_q;
    logic [ADDR-1:0] com_tar_q;

    assign flush  = !bus.flush_;
    assign dec_v  = !bus.dec_e_;
    assign wb_v   = !bus.wb_e_;
    assign com_v  = !bus.commit_;
    assign dec_id = bus.dec_rob_id;
    assign wb_id  = bus.wb_rob_id;
    assign com_id = bus.com_rob_id;

    // Writeback lands only on a live slot that decode is not refilling.
    assign wb_we = wb_v
                 && (status_q[wb_id] != ST_EMPTY)
                 && !(dec_v && (dec_id == wb_id));

    assign wb_byp = wb_we && (wb_id == com_id);

    assign com_fire = com_v && !flush
                    && ((status_q[com_id] == ST_RESOLVED) || wb_byp);

    br_record_table #(
        .ADDR  (ADDR),
        .DEPTH (ROB_DEPTH),
        .ID_W  (ROB)
    ) u_table (
        .clk           (clk),
        .reset_        (reset_),
        .dec_we        (dec_v),
        .dec_id        (dec_id),
        .dec_kind      (bus.dec_type),
        .dec_pc        (bus.dec_pc),
        .dec_pred_addr (bus.dec_pred_addr),
        .dec_br_pred   (bus.dec_br_pred),
        .wb_we         (wb_we),
        .wb_id         (wb_id),
        .wb_tar_pc     (bus.wb_tar_pc),
        .wb_taken      (!bus.wb_taken_),
        .wb_pred_miss  (!bus.wb_pred_miss_),
        .wb_jump_miss  (!bus.wb_jump_miss_),
        .exe_id        (bus.exe_rob_id),
        .exe_pred_addr (t_exe_pred),
        .exe_br_pred   (t_exe_brp),
        .com_id        (com_id),
        .com_kind      (t_kind),
        .com_pc        (t_pc),
        .com_tar_pc    (t_tar),
        .com_taken     (t_taken),
        .com_pred_miss (t_pmiss),
        .com_jump_miss (t_jmiss)
    );

    // An empty slot reads back as no prediction.
    assign bus.exe_pred_addr = (status_q[bus.exe_rob_id] == ST_EMPTY)
                             ? '0 : t_exe_pred;
    assign bus.exe_br_pred   = (status_q[bus.exe_rob_id] != ST_EMPTY)
                             && t_exe_brp;

    assign c_tar   = wb_byp ? bus.wb_tar_pc      : t_tar;
    assign c_taken = wb_byp ? !bus.wb_taken_     : t_taken;
    assign c_pmiss = wb_byp ? !bus.wb_pred_miss_ : t_pmiss;
    assign c_jmiss = wb_byp ? !bus.wb_jump_miss_ : t_jmiss;

    // Slot state register.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                status_q[i] <= ST_EMPTY;
            end
        end else begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                status_q[i] <= status_d[i];
            end
        end
    end

    // Slot next state: flush, then decode, then commit, then writeback.
    always_comb begin
        for (int i = 0; i < ROB_DEPTH; i++) begin
            status_d[i] = status_q[i];
            if (flush) begin
                status_d[i] = ST_EMPTY;
            end else if (dec_v && (dec_id == ROB'(i))) begin
                status_d[i] = ST_DECODED;
            end else if (com_v && (com_id == ROB'(i))) begin
                status_d[i] = ST_EMPTY;
            end else if (wb_we && (wb_id == ROB'(i))) begin
                status_d[i] = ST_RESOLVED;
            end
        end
    end

    // Strobe pattern for the record being committed.
    always_comb begin
        strb_d = STRB_IDLE;
        if (t_kind == BRTYPE_BRANCH) begin
            strb_d[6] = 1'b0;
            strb_d[5] = !c_taken;
            strb_d[4] = !c_pmiss;
        end else begin
            strb_d[3] = 1'b0;
            strb_d[2] = (t_kind != BRTYPE_CALL);
            strb_d[1] = (t_kind != BRTYPE_RETURN);
            strb_d[0] = !c_jmiss;
        end
    end

    // Registered single-cycle update pulses and committed addresses.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            strb_q     <= STRB_IDLE;
            com_addr_q <= '0;
            com_tar_q  <= '0;
        end else if (flush) begin
            strb_q     <= STRB_IDLE;
            com_addr_q <= '0;
            com_tar_q  <= '0;
        end else begin
            strb_q <= STRB_IDLE;
            if (com_fire) begin
                strb_q     <= strb_d;
                com_addr_q <= t_pc;
                com_tar_q  <= c_tar;
            end
        end
    end

    assign bus.br_commit_   = strb_q[6];
    assign bus.br_taken_    = strb_q[5];
    assign bus.br_miss_     = strb_q[4];
    assign bus.jump_commit_ = strb_q[3];
    assign bus.jump_call_   = strb_q[2];
    assign bus.jump_return_ = strb_q[1];
    assign bus.jump_miss_   = strb_q[0];
    assign bus.com_addr     = com_addr_q;
    assign bus.com_tar_addr = com_tar_q;

`ifdef BR_COMMIT_STAT_EN
    logic [31:0] br_cnt_q;
    logic [31:0] miss_cnt_q;

    // Saturating counts of emitted commit and miss pulses; flush keeps them.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            if ((!strb_q[6] || !strb_q[3]) && (br_cnt_q != '1)) begin
                br_cnt_q <= br_cnt_q + 32'd1;
            end
            if ((!strb_q[4] || !strb_q[0]) && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign bus.stat_br_cnt   = br_cnt_q;
    assign bus.stat_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_br_commit_unit.sv
// Self-checking bench for br_commit_unit: vector table plus
// hand-written corner sequences, commit results via a scoreboard queue.
module tb_br_commit_unit;
    import br_commit_unit_pkg::*;

    logic clk = 1'b0;
    logic reset_;

    always #5 clk = ~clk;

    br_commit_unit_if bus ();

    br_commit_unit dut (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [6:0]  strb;
        logic [31:0] addr;
        logic [31:0] tar;
        bit          chk_addr;
    } exp_t;

    typedef struct {
        br_inst_type_t    kind;
        logic [ROB_W-1:0] id;
        logic [31:0]      pc;
        logic [31:0]      pred;
        logic             brp;
        logic [31:0]      tar;
        logic             taken_;
        logic             pmiss_;
        logic             jmiss_;
        logic [6:0]       strb;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[5];

    function automatic logic [6:0] strobes();
        return {bus.br_commit_, bus.br_taken_, bus.br_miss_,
                bus.jump_commit_, bus.jump_call_,
                bus.jump_return_, bus.jump_miss_};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic idle();
        bus.flush_  = 1'b1;
        bus.dec_e_  = 1'b1;
        bus.wb_e_   = 1'b1;
        bus.commit_ = 1'b1;
    endtask

    task automatic set_dec(input br_inst_type_t k, input logic [ROB_W-1:0] id,
                           input logic [31:0] pc, input logic [31:0] pred,
                           input logic brp);
        bus.dec_e_        = 1'b0;
        bus.dec_type      = k;
        bus.dec_rob_id    = id;
        bus.dec_pc        = pc;
        bus.dec_pred_addr = pred;
        bus.dec_br_pred   = brp;
    endtask

    task automatic set_wb(input logic [ROB_W-1:0] id, input logic [31:0] tar,
                          input logic tk_, input logic pm_, input logic jm_);
        bus.wb_e_         = 1'b0;
        bus.wb_rob_id     = id;
        bus.wb_tar_pc     = tar;
        bus.wb_taken_     = tk_;
        bus.wb_pred_miss_ = pm_;
        bus.wb_jump_miss_ = jm_;
    endtask

    task automatic set_com(input logic [ROB_W-1:0] id, input exp_t e);
        bus.commit_    = 1'b0;
        bus.com_rob_id = id;
        sb.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
        idle();
    endtask

    task automatic check_commit(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            n_total++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sb.pop_front();
            chk({nm, "_strb"}, 64'(strobes()), 64'(e.strb));
            if (e.chk_addr) begin
                chk({nm, "_addr"}, 64'(bus.com_addr), 64'(e.addr));
                chk({nm, "_tar"}, 64'(bus.com_tar_addr), 64'(e.tar));
            end
        end
    endtask

    task automatic chk_exe(input string nm, input logic [ROB_W-1:0] id,
                           input logic [31:0] pred, input logic brp);
        bus.exe_rob_id = id;
        #1;
        chk({nm, "_pred"}, 64'(bus.exe_pred_addr), 64'(pred));
        chk({nm, "_brp"}, 64'(bus.exe_br_pred), 64'(brp));
    endtask

    localparam exp_t NONE = '{STRB_IDLE, 32'h0, 32'h0, 1'b0};

`ifdef BR_COMMIT_STAT_EN
    logic [31:0] br0;
    logic [31:0] miss0;
`endif

    initial begin
        vecs[0] = '{BRTYPE_BRANCH, 3'd5, 32'h100, 32'h140, 1'b1,
                    32'h140, 1'b0, 1'b1, 1'b1, 7'b0011111};
        vecs[1] = '{BRTYPE_CALL, 3'd2, 32'h200, 32'h250, 1'b0,
                    32'h300, 1'b0, 1'b1, 1'b0, 7'b1110010};
        vecs[2] = '{BRTYPE_BRANCH, 3'd3, 32'h300, 32'h340, 1'b1,
                    32'h304, 1'b1, 1'b0, 1'b1, 7'b0101111};
        vecs[3] = '{BRTYPE_RETURN, 3'd4, 32'h400, 32'h500, 1'b0,
                    32'h504, 1'b0, 1'b1, 1'b1, 7'b1110101};
        vecs[4] = '{BRTYPE_JUMP, 3'd6, 32'h600, 32'h700, 1'b0,
                    32'h780, 1'b0, 1'b1, 1'b0, 7'b1110110};

        idle();
        bus.dec_type      = BRTYPE_BRANCH;
        bus.dec_rob_id    = '0;
        bus.dec_pc        = '0;
        bus.dec_pred_addr = '0;
        bus.dec_br_pred   = 1'b0;
        bus.exe_rob_id    = '0;
        bus.wb_rob_id     = '0;
        bus.wb_tar_pc     = '0;
        bus.wb_taken_     = 1'b1;
        bus.wb_pred_miss_ = 1'b1;
        bus.wb_jump_miss_ = 1'b1;
        bus.com_rob_id    = '0;
        reset_ = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_strb", 64'(strobes()), 64'(STRB_IDLE));
        chk("rst_addr", 64'(bus.com_addr), 64'h0);
        reset_ = 1'b1;
        @(negedge clk);
        chk("rel_strb", 64'(strobes()), 64'(STRB_IDLE));
        chk("rel_tar", 64'(bus.com_tar_addr), 64'h0);
`ifdef BR_COMMIT_STAT_EN
        chk("rst_stat", 64'(bus.stat_br_cnt), 64'h0);
`endif

        set_com(3'd3, '{STRB_IDLE, 32'h0, 32'h0, 1'b1});
        step();
        check_commit("empty_com");

        for (int k = 0; k < 5; k++) begin
            vec_t v;
            v = vecs[k];
            set_dec(v.kind, v.id, v.pc, v.pred, v.brp);
            step();
            chk_exe($sformatf("v%0d_exe", k), v.id, v.pred, v.brp);
            set_wb(v.id, v.tar, v.taken_, v.pmiss_, v.jmiss_);
            step();
            set_com(v.id, '{v.strb, v.pc, v.tar, 1'b1});
            step();
            check_commit($sformatf("v%0d", k));
            step();
            chk($sformatf("v%0d_pulse", k), 64'(strobes()), 64'(STRB_IDLE));
        end

        set_dec(BRTYPE_BRANCH, 3'd7, 32'h70, 32'h90, 1'b1);
        step();
        set_wb(3'd7, 32'h80, 1'b0, 1'b1, 1'b1);
        set_com(3'd7, '{7'b0011111, 32'h70, 32'h80, 1'b1});
        step();
        check_commit("bypass");
        chk_exe("bypass_free", 3'd7, 32'h0, 1'b0);
        set_com(3'd7, NONE);
        step();
        check_commit("bypass_again");

        set_dec(BRTYPE_JUMP, 3'd1, 32'h10, 32'h20, 1'b0);
        step();
        set_wb(3'd1, 32'h24, 1'b0, 1'b1, 1'b0);
        step();
        set_dec(BRTYPE_CALL, 3'd1, 32'h30, 32'h44, 1'b0);
        set_com(3'd1, '{7'b1110110, 32'h10, 32'h24, 1'b1});
        step();
        check_commit("dec_com_old");
        chk_exe("dec_com_new", 3'd1, 32'h44, 1'b0);
        set_com(3'd1, NONE);
        step();
        check_commit("decoded_free");
        chk_exe("decoded_gone", 3'd1, 32'h0, 1'b0);

        set_dec(BRTYPE_BRANCH, 3'd0, 32'h50, 32'h60, 1'b1);
        step();
        set_dec(BRTYPE_BRANCH, 3'd0, 32'h54, 32'h64, 1'b0);
        set_wb(3'd0, 32'h99, 1'b0, 1'b0, 1'b1);
        step();
        chk_exe("dec_wb", 3'd0, 32'h64, 1'b0);
        set_com(3'd0, NONE);
        step();
        check_commit("dec_wins");

        set_dec(BRTYPE_BRANCH, 3'd2, 32'h220, 32'h230, 1'b1);
        step();
        set_wb(3'd2, 32'h230, 1'b0, 1'b1, 1'b1);
        step();
        set_wb(3'd2, 32'h240, 1'b1, 1'b0, 1'b1);
        step();
        set_com(3'd2, '{7'b0101111, 32'h220, 32'h240, 1'b1});
        step();
        check_commit("wb_over");

        set_wb(3'd5, 32'h555, 1'b0, 1'b0, 1'b0);
        step();
        set_com(3'd5, NONE);
        step();
        check_commit("wb_empty");

        set_dec(BRTYPE_BRANCH, 3'd1, 32'h11, 32'h12, 1'b1);
        step();
        set_dec(BRTYPE_JUMP, 3'd2, 32'h21, 32'h22, 1'b1);
        set_wb(3'd1, 32'h12, 1'b0, 1'b1, 1'b1);
        step();
        set_wb(3'd2, 32'h22, 1'b0, 1'b1, 1'b1);
        step();
        bus.flush_ = 1'b0;
        step();
        set_com(3'd1, '{STRB_IDLE, 32'h0, 32'h0, 1'b1});
        step();
        check_commit("flush_com");
        chk_exe("flush_exe", 3'd2, 32'h0, 1'b0);

        set_dec(BRTYPE_BRANCH, 3'd3, 32'h33, 32'h34, 1'b0);
        step();
        set_wb(3'd3, 32'h34, 1'b1, 1'b1, 1'b1);
        step();
        bus.flush_ = 1'b0;
        set_com(3'd3, NONE);
        step();
        check_commit("flush_wins");

`ifdef BR_COMMIT_STAT_EN
        br0   = bus.stat_br_cnt;
        miss0 = bus.stat_miss_cnt;
`endif
        set_dec(BRTYPE_BRANCH, 3'd7, 32'h700, 32'h710, 1'b1);
        step();
        set_dec(BRTYPE_CALL, 3'd0, 32'h800, 32'h900, 1'b0);
        set_wb(3'd7, 32'h710, 1'b0, 1'b1, 1'b1);
        step();
        set_wb(3'd0, 32'h900, 1'b0, 1'b1, 1'b1);
        step();
        set_com(3'd7, '{7'b0011111, 32'h700, 32'h710, 1'b1});
        step();
        check_commit("wrap_hi");
        set_com(3'd0, '{7'b1110011, 32'h800, 32'h900, 1'b1});
        step();
        check_commit("wrap_lo");
        step();
        chk("wrap_pulse", 64'(strobes()), 64'(STRB_IDLE));
`ifdef BR_COMMIT_STAT_EN
        chk("stat_br", 64'(bus.stat_br_cnt - br0), 64'd2);
        chk("stat_miss", 64'(bus.stat_miss_cnt - miss0), 64'd0);
`endif

        set_dec(BRTYPE_BRANCH, 3'd4, 32'h440, 32'h480, 1'b1);
        step();
        set_wb(3'd4, 32'h444, 1'b1, 1'b0, 1'b1);
        step();
        set_com(3'd4, '{7'b0101111, 32'h440, 32'h444, 1'b1});
        step();
        check_commit("pre_rst");
        #2;
        reset_ = 1'b0;
        #1;
        chk("async_strb", 64'(strobes()), 64'(STRB_IDLE));
        chk("async_addr", 64'(bus.com_addr), 64'h0);
`ifdef BR_COMMIT_STAT_EN
        chk("async_stat", 64'(bus.stat_miss_cnt), 64'h0);
`endif
        @(negedge clk);
        reset_ = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
